// File: rtl/clm_rand_pkg.sv
// Shared types, FSM encoding and LFSR helpers for the CLM randomness feeder.
package clm_rand_pkg;

  localparam int unsigned RED_POLY_W = 4;
  localparam int unsigned P_DET_BITS = 4;

  typedef logic [RED_POLY_W-1:0] red_poly_t;
  typedef logic [P_DET_BITS-1:0] p_det_t;

  typedef enum logic [2:0] {IDLE, FILL, PDET, START, WAIT} feeder_state_t;

  // x^32 + x^22 + x^2 + x + 1, Galois form, shifting right
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step_n(input logic [31:0] s, input int unsigned n);
    logic [31:0] r;
    r = s;
    for (int unsigned i = 0; i < n; i++) begin
      r = (r >> 1) ^ (r[0] ? LFSR_TAPS : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/clm_lfsr_stepper.sv
// Combinational Galois LFSR advance by a fixed number of unrolled steps.
module clm_lfsr_stepper
  import clm_rand_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned STEPS = 4
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] Taps = W'(LFSR_TAPS);

  logic [W-1:0] s;

  always_comb begin
    s = cur;
    for (int unsigned i = 0; i < STEPS; i++) begin
      s = (s >> 1) ^ (s[0] ? Taps : '0);
    end
    nxt = s;
  end

endmodule

// File: rtl/clm_rand_feeder.sv
// Draws per-encryption masks and p_det from an LFSR and launches the CLM AES core.
// Optional CLM_RAND_RESEED_EN adds entropy_i, mixed into the LFSR on each accepted request.
module clm_rand_feeder
  import clm_rand_pkg::*;
#(
  parameter int unsigned      D       = $bits(red_poly_t),
  parameter int unsigned      N_WORDS = 23,
  parameter int unsigned      P_DET_W = $bits(p_det_t),
  parameter int unsigned      LFSR_W  = 32,
  parameter logic [LFSR_W-1:0] SEED    = 'h1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LFSR_W-1:0]          seed_i,
  input  logic                       seed_load_i,
  input  logic                       req_i,
  output logic                       busy_o,
  output logic [N_WORDS-1:0][D-1:0]  random_vect_o,
  output logic [P_DET_W-1:0]         p_det_o,
  output logic                       core_start_o,
  input  logic                       core_done_i,
  output logic                       done_o
`ifdef CLM_RAND_RESEED_EN
  ,
  input  logic [LFSR_W-1:0]          entropy_i
`endif
);

  localparam int unsigned        CtrW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CtrW-1:0]    LastWord = CtrW'(N_WORDS - 1);
  localparam logic [LFSR_W-1:0]  SeedNz   = (SEED == '0) ? LFSR_W'(1) : SEED;

  // The all-zero state is a lock-up point of the LFSR.
  function automatic logic [LFSR_W-1:0] nz(input logic [LFSR_W-1:0] v);
    return (v == '0) ? LFSR_W'(1) : v;
  endfunction

  feeder_state_t               state_q, state_d;
  logic [LFSR_W-1:0]           lfsr_q, lfsr_step;
  logic [CtrW-1:0]             word_ctr_q;
  logic [N_WORDS-1:0][D-1:0]   vect_q;
  logic [P_DET_W-1:0]          p_det_q;
  logic [P_DET_W-1:0]          cand;
  logic                        done_q;

  clm_lfsr_stepper #(
    .W     (LFSR_W),
    .STEPS (D)
  ) u_stepper (
    .cur (lfsr_q),
    .nxt (lfsr_step)
  );

  assign cand = lfsr_step[P_DET_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!seed_load_i && req_i) state_d = FILL;
      FILL:    if (word_ctr_q == LastWord) state_d = PDET;
      PDET:    if (cand != '0) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (core_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != IDLE);
    core_start_o  = (state_q == START);
    done_o        = done_q;
    random_vect_o = vect_q;
    p_det_o       = p_det_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q     <= SeedNz;
      word_ctr_q <= '0;
      vect_q     <= '0;
      p_det_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == WAIT) && core_done_i;
      case (state_q)
        IDLE: begin
          // A seed load wins and the concurrent request is dropped.
          if (seed_load_i) begin
            lfsr_q <= nz(seed_i);
          end else if (req_i) begin
            word_ctr_q <= '0;
`ifdef CLM_RAND_RESEED_EN
            lfsr_q     <= nz(lfsr_q ^ entropy_i);
`endif
          end
        end
        FILL: begin
          lfsr_q             <= lfsr_step;
          vect_q[word_ctr_q] <= lfsr_step[D-1:0];
          word_ctr_q         <= word_ctr_q + CtrW'(1);
        end
        PDET: begin
          lfsr_q <= lfsr_step;
          if (cand != '0) p_det_q <= cand;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clm_rand_feeder.sv
// Self-checking bench for clm_rand_feeder: seed table plus directed multi-cycle sequences.
module tb_clm_rand_feeder;
  import clm_rand_pkg::*;

  localparam int unsigned D  = 4;
  localparam int unsigned NW = 23;
  localparam int unsigned PW = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [31:0]             seed_i = '0;
  logic                    seed_load_i = 1'b0;
  logic                    req_i = 1'b0;
  logic                    core_done_i = 1'b0;
  logic                    busy_o;
  logic                    core_start_o;
  logic                    done_o;
  logic [NW-1:0][D-1:0]    random_vect_o;
  logic [PW-1:0]           p_det_o;
`ifdef CLM_RAND_RESEED_EN
  logic [31:0]             entropy_i = '0;
`endif

  always #5 clk = ~clk;

  clm_rand_feeder #(
    .D       (D),
    .N_WORDS (NW),
    .P_DET_W (PW),
    .LFSR_W  (32),
    .SEED    (32'h0000_0001)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .seed_i        (seed_i),
    .seed_load_i   (seed_load_i),
    .req_i         (req_i),
    .busy_o        (busy_o),
    .random_vect_o (random_vect_o),
    .p_det_o       (p_det_o),
    .core_start_o  (core_start_o),
    .core_done_i   (core_done_i),
    .done_o        (done_o)
`ifdef CLM_RAND_RESEED_EN
    ,
    .entropy_i     (entropy_i)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model
  logic [31:0] m_lfsr;

  function automatic logic [31:0] m_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] m_nz(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic model_run(output logic [NW-1:0][D-1:0] v, output logic [PW-1:0] p,
                           output int redraws);
    logic [31:0] s;
    s = m_lfsr;
`ifdef CLM_RAND_RESEED_EN
    s = m_nz(s ^ entropy_i);
`endif
    for (int w = 0; w < NW; w++) begin
      repeat (D) s = m_step(s);
      v[w] = s[D-1:0];
    end
    redraws = 0;
    repeat (D) s = m_step(s);
    while (s[PW-1:0] == '0) begin
      redraws++;
      repeat (D) s = m_step(s);
    end
    p = s[PW-1:0];
    m_lfsr = s;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_i = s;
    seed_load_i = 1'b1;
    tick();
    seed_load_i = 1'b0;
    m_lfsr = m_nz(s);
  endtask

  // One full encryption handshake from IDLE; returns req-to-start latency.
  task automatic run_enc(input int done_delay, input bit pulse_in_start, input bit poke_in_wait,
                         output int latency);
    logic [NW-1:0][D-1:0] v0;
    logic [PW-1:0]        p0;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    check("busy_rise", 128'(busy_o), 128'(1));
    latency = 1;
    while (!core_start_o && latency < 100) begin
      tick();
      latency++;
    end
    v0 = random_vect_o;
    p0 = p_det_o;
    if (pulse_in_start) core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    for (int i = 0; i < done_delay; i++) begin
      check("wait_stable", 128'({p_det_o, random_vect_o}), 128'({p0, v0}));
      check("wait_no_done", 128'({done_o, core_start_o}), 128'(0));
      check("wait_busy", 128'(busy_o), 128'(1));
      req_i       = poke_in_wait && (i == 0);
      seed_load_i = poke_in_wait && (i == 0);
      seed_i      = 32'h0000_1234;
      tick();
    end
    req_i = 1'b0;
    seed_load_i = 1'b0;
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    check("done_pulse", 128'({done_o, busy_o}), 128'(2'b10));
    check("done_stable", 128'({p_det_o, random_vect_o}), 128'({p0, v0}));
    tick();
    check("done_clear", 128'({done_o, busy_o, core_start_o}), 128'(0));
  endtask

  task automatic do_and_check(input string tag, input int done_delay, input bit pulse,
                              input bit poke);
    logic [NW-1:0][D-1:0] ev;
    logic [PW-1:0]        ep;
    int                   rd;
    int                   lat;
    model_run(ev, ep, rd);
    run_enc(done_delay, pulse, poke, lat);
    check({tag, "_latency"}, 128'(lat), 128'(25 + rd));
    check({tag, "_vect"}, 128'(random_vect_o), 128'(ev));
    check({tag, "_pdet"}, 128'(p_det_o), 128'(ep));
    check({tag, "_pdet_nz"}, 128'(p_det_o != '0), 128'(1));
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [3:0]  w0;
    logic [3:0]  w1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [NW-1:0][D-1:0] sv_v, tv;
    logic [PW-1:0]        sv_p, tp;
    int                   trd;
    int                   strays;
    logic [31:0]          zseed;
    bit                   found;

    tbl[0] = '{seed: 32'h0000_0000, w0: 4'h3, w1: 4'h2};
    tbl[1] = '{seed: 32'h0000_0001, w0: 4'h3, w1: 4'h2};
    tbl[2] = '{seed: 32'h0000_0002, w0: 4'h1, w1: 4'h3};
    tbl[3] = '{seed: 32'h0000_0010, w0: 4'h1, w1: 4'h3};
    tbl[4] = '{seed: 32'h8000_0000, w0: 4'h0, w1: 4'h0};

    // Reset values
    rst = 1'b0;
    tick();
    tick();
    check("reset_ctrl", 128'({busy_o, core_start_o, done_o}), 128'(0));
    check("reset_vect", 128'(random_vect_o), 128'(0));
    check("reset_pdet", 128'(p_det_o), 128'(0));
    rst = 1'b1;
    m_lfsr = 32'h1;

    // First run from the reset seed
    do_and_check("reset_seed_run", 0, 1'b0, 1'b0);
    check("reset_seed_w0", 128'(random_vect_o[0]), 128'(4'h3));
    check("reset_seed_w1", 128'(random_vect_o[1]), 128'(4'h2));

    for (int i = 0; i < 5; i++) begin
      load_seed(tbl[i].seed);
      do_and_check("tbl", 1, 1'b0, 1'b0);
      check("tbl_w0", 128'(random_vect_o[0]), 128'(tbl[i].w0));
      check("tbl_w1", 128'(random_vect_o[1]), 128'(tbl[i].w1));
    end

    // Same seed twice gives identical draws
    load_seed(32'h0000_0005);
    do_and_check("repeat_a", 0, 1'b0, 1'b0);
    sv_v = random_vect_o;
    sv_p = p_det_o;
    load_seed(32'h0000_0005);
    do_and_check("repeat_b", 0, 1'b0, 1'b0);
    check("repeat_same", 128'({p_det_o, random_vect_o}), 128'({sv_p, sv_v}));

    // seed_load_i beats req_i in the same cycle
    seed_i = 32'h0000_0002;
    seed_load_i = 1'b1;
    req_i = 1'b1;
    tick();
    seed_load_i = 1'b0;
    req_i = 1'b0;
    m_lfsr = 32'h2;
    check("load_req_busy", 128'(busy_o), 128'(0));
    tick();
    check("load_req_idle", 128'({busy_o, core_start_o}), 128'(0));
    do_and_check("load_req_run", 0, 1'b0, 1'b0);
    check("load_req_w0", 128'(random_vect_o[0]), 128'(4'h1));

    // Seed whose first p_det candidate is zero
    found = 1'b0;
    zseed = 32'h0;
    for (int s = 1; s < 4000 && !found; s++) begin
      m_lfsr = 32'(s);
      model_run(tv, tp, trd);
      if (trd > 0) begin
        found = 1'b1;
        zseed = 32'(s);
      end
    end
    if (found) begin
      load_seed(zseed);
      do_and_check("zero_pdet", 0, 1'b0, 1'b0);
    end else begin
      n_checks++;
      $display("FAIL zero_pdet_seed: got none, want a seed with a zero candidate");
    end

    // done pulse during START is ignored; real done at WAIT+5
    do_and_check("done_in_start", 5, 1'b1, 1'b0);

    // Reset in the middle of FILL
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midreset_ctrl", 128'({busy_o, core_start_o, done_o}), 128'(0));
    check("midreset_data", 128'({p_det_o, random_vect_o}), 128'(0));
    strays = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (core_start_o || done_o || busy_o) strays++;
    end
    check("midreset_quiet", 128'(strays), 128'(0));
    m_lfsr = 32'h1;
    do_and_check("after_reset", 0, 1'b0, 1'b0);
    check("after_reset_w0", 128'(random_vect_o[0]), 128'(4'h3));

    // req_i / seed_load_i during WAIT are dropped
    do_and_check("poke_wait", 3, 1'b0, 1'b1);
    do_and_check("after_poke", 0, 1'b0, 1'b0);

`ifdef CLM_RAND_RESEED_EN
    load_seed(32'h1);
    do_and_check("reseed_base", 0, 1'b0, 1'b0);
    check("reseed_base_w0", 128'(random_vect_o[0]), 128'(4'h3));
    load_seed(32'h1);
    entropy_i = 32'hDEAD_BEEF;
    do_and_check("reseed_mix", 0, 1'b0, 1'b0);
    check("reseed_mix_w0", 128'(random_vect_o[0]), 128'(4'hE));
    entropy_i = 32'h0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
